// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC output path: rounding-mode codes,
// output-buffer occupancy states and lane-packing helpers.
package cordic_pkg;

    localparam logic [1:0] RND_TRUNC  = 2'd0;
    localparam logic [1:0] RND_HALFUP = 2'd1;
    localparam logic [1:0] RND_CONV   = 2'd2;

    // Occupancy of the 2-entry output buffer, used directly as FSM state
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    // Lowest bit of lane k in a bus of lanes that are w bits wide
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/op_round_sat.sv
// Single-lane combinational narrowing from CORDIC_WIDTH to DATA_WIDTH with
// selectable rounding and positive saturation.
module op_round_sat
    import cordic_pkg::*;
#(
    parameter int CORDIC_WIDTH = 22,
    parameter int DATA_WIDTH   = 16
) (
    input  logic [CORDIC_WIDTH-1:0] in,
    input  logic [1:0]              mode,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    sat
);

    localparam int S = CORDIC_WIDTH - DATA_WIDTH;
    localparam logic [S-1:0] TIE_PAT = S'(1) << (S - 1);
    localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Adding 2^(S-1) carries into bit S exactly when bit S-1 is set, so the
    // rounding reduces to a single increment of the truncated value.
    function automatic logic round_inc(input logic [CORDIC_WIDTH-1:0] v,
                                       input logic [1:0] m);
        logic tie;
        logic inc;
        tie = (v[S-1:0] == TIE_PAT);
        case (m)
            RND_TRUNC:  inc = 1'b0;
            RND_HALFUP: inc = v[S-1];
            RND_CONV:   inc = v[S-1] & ~(tie & ~v[S]);
            default:    inc = 1'b0;
        endcase
        return inc;
    endfunction

    // Only the positive limit can be crossed because rounding never subtracts
    function automatic logic is_over(input logic signed [DATA_WIDTH:0] r);
        return ~r[DATA_WIDTH] & r[DATA_WIDTH-1];
    endfunction

    logic signed [DATA_WIDTH:0] rnd;

    // Sign-extended truncated value plus rounding increment, then clamp
    always_comb begin
        rnd = $signed({in[CORDIC_WIDTH-1], in[CORDIC_WIDTH-1:S]})
            + $signed({{DATA_WIDTH{1'b0}}, round_inc(in, mode)});
        sat = is_over(rnd);
        out = sat ? POS_MAX : rnd[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/op_rescale_multi.sv
// Multi-lane CORDIC output rescaler: per-lane round/saturate feeding a
// 2-entry output buffer with a registered in_rdy and a sticky saturation flag.
module op_rescale_multi
    import cordic_pkg::*;
#(
    parameter int CORDIC_WIDTH = 22,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 2
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [NUM_CH*CORDIC_WIDTH-1:0] in_data,
    input  logic [1:0]                   round_mode,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_sat,
    output logic                         sat_sticky,
    input  logic                         sat_clr
);

    localparam int OW = NUM_CH * DATA_WIDTH;

    logic [OW-1:0]     rnd_data;
    logic [NUM_CH-1:0] rnd_sat;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            op_round_sat #(
                .CORDIC_WIDTH (CORDIC_WIDTH),
                .DATA_WIDTH   (DATA_WIDTH)
            ) u_round_sat (
                .in   (in_data[lane_lo(k, CORDIC_WIDTH) +: CORDIC_WIDTH]),
                .mode (round_mode),
                .out  (rnd_data[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
                .sat  (rnd_sat[k])
            );
        end
    endgenerate

    occ_state_e        occ_q, occ_d;
    logic [OW-1:0]     data_q [2];
    logic [OW-1:0]     data_d [2];
    logic [NUM_CH-1:0] sat_q  [2];
    logic [NUM_CH-1:0] sat_d  [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              in_rdy_q, in_rdy_d;
    logic              sticky_q, sticky_d;
    logic              push;
    logic              pop;

    assign push       = in_vld & in_rdy_q;
    assign pop        = (occ_q != OCC_EMPTY) & out_rdy;
    assign in_rdy     = in_rdy_q;
    assign out_vld    = (occ_q != OCC_EMPTY);
    assign out_data   = data_q[rd_ptr_q];
    assign out_sat    = sat_q[rd_ptr_q];
    assign sat_sticky = sticky_q;

    // Occupancy FSM next state; in_rdy is precomputed so it leaves a flop
    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            OCC_EMPTY: if (push)         occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)        occ_d = OCC_FULL;
                else if (pop && !push)   occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop)          occ_d = OCC_ONE;
            default:                     occ_d = OCC_EMPTY;
        endcase
        in_rdy_d = (occ_d != OCC_FULL);
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            occ_q    <= OCC_EMPTY;
            in_rdy_q <= 1'b1;
        end else begin
            occ_q    <= occ_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    // Buffer write/read pointers, storage and sticky flag (set beats clear)
    always_comb begin
        data_d   = data_q;
        sat_d    = sat_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sticky_d = sticky_q;
        if (push) begin
            data_d[wr_ptr_q] = rnd_data;
            sat_d[wr_ptr_q]  = rnd_sat;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && (|rnd_sat)) begin
            sticky_d = 1'b1;
        end else if (sat_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Storage is reset too so a freshly reset block presents all-zero data
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            sat_q[0]  <= '0;
            sat_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            sat_q    <= sat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_op_rescale_multi.sv
// Self-checking bench for op_rescale_multi: directed vector table, sticky
// flag sequences, backpressure, random streaming and mid-transfer reset.
module tb_op_rescale_multi;

    localparam int CW = 22;
    localparam int DW = 16;
    localparam int NC = 2;
    localparam int S  = CW - DW;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [NC*CW-1:0]  in_data = '0;
    logic [1:0]        round_mode = 2'd0;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [NC*DW-1:0]  out_data;
    logic [NC-1:0]     out_sat;
    logic              sat_sticky;
    logic              sat_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    op_rescale_multi #(
        .CORDIC_WIDTH (CW),
        .DATA_WIDTH   (DW),
        .NUM_CH       (NC)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .round_mode (round_mode),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: treat the lane as an integer, divide by 2^S with the
    // requested rounding rule, then clamp at the positive limit.
    function automatic logic [DW-1:0] mdl_lane(input logic [CW-1:0] raw,
                                               input logic [1:0] mode,
                                               output logic sat);
        int v, fl, r, q, half;
        v    = int'($signed(raw));
        half = 1 << (S - 1);
        fl   = v >>> S;
        r    = v - fl * (1 << S);
        case (mode)
            2'd1:    q = (v + half) >>> S;
            2'd2:    q = (r == half) ? fl + (fl & 1) : (v + half) >>> S;
            default: q = fl;
        endcase
        sat = (q > (1 << (DW - 1)) - 1);
        return sat ? {1'b0, {(DW-1){1'b1}}} : q[DW-1:0];
    endfunction

    task automatic mdl_beat(input logic [NC*CW-1:0] d, input logic [1:0] mode,
                            output logic [NC*DW-1:0] od, output logic [NC-1:0] os);
        logic s;
        for (int k = 0; k < NC; k++) begin
            od[k*DW +: DW] = mdl_lane(d[k*CW +: CW], mode, s);
            os[k] = s;
        end
    endtask

    function automatic logic [NC*CW-1:0] rnd_beat(input int i);
        logic [NC*CW-1:0] d;
        for (int k = 0; k < NC; k++) d[k*CW +: CW] = CW'($urandom);
        if (i % 4 == 0) d[CW-1:0] = 22'h1FFF00 | CW'($urandom_range(0, 255));
        return d;
    endfunction

    typedef struct {
        logic [1:0]    mode;
        logic [CW-1:0] l0;
        logic [CW-1:0] l1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [1:0]    es;
    } vec_t;

    vec_t vecs [11];

    logic [NC*DW-1:0] q_d [$];
    logic [NC-1:0]    q_s [$];
    logic [NC*CW-1:0] bd [3];
    logic [1:0]       bm [3];
    logic [NC*DW-1:0] be_d [3];
    logic [NC-1:0]    be_s [3];
    logic [NC*DW-1:0] ed;
    logic [NC-1:0]    es;

    initial begin
        vecs[0]  = '{2'd0, 22'h000045, 22'h3FFFBB, 16'h0001, 16'hFFFE, 2'b00};
        vecs[1]  = '{2'd1, 22'h000060, 22'h0000A0, 16'h0002, 16'h0003, 2'b00};
        vecs[2]  = '{2'd2, 22'h000060, 22'h0000A0, 16'h0002, 16'h0002, 2'b00};
        vecs[3]  = '{2'd1, 22'h000050, 22'h000050, 16'h0001, 16'h0001, 2'b00};
        vecs[4]  = '{2'd2, 22'h000050, 22'h000050, 16'h0001, 16'h0001, 2'b00};
        vecs[5]  = '{2'd0, 22'h1FFFFF, 22'h000000, 16'h7FFF, 16'h0000, 2'b00};
        vecs[6]  = '{2'd3, 22'h000045, 22'h3FFFBB, 16'h0001, 16'hFFFE, 2'b00};
        vecs[7]  = '{2'd2, 22'h3FFFE0, 22'h3FFFA0, 16'h0000, 16'hFFFE, 2'b00};
        vecs[8]  = '{2'd1, 22'h3FFFE0, 22'h3FFFA0, 16'h0000, 16'hFFFF, 2'b00};
        vecs[9]  = '{2'd1, 22'h1FFFFF, 22'h200000, 16'h7FFF, 16'h8000, 2'b01};
        vecs[10] = '{2'd2, 22'h000000, 22'h1FFFE0, 16'h0000, 16'h7FFF, 2'b10};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_out_vld", out_vld, 1'b0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_sat", out_sat, '0);
        chk("reset_in_rdy", in_rdy, 1'b1);
        chk("reset_sticky", sat_sticky, 1'b0);
        nreset  = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);

        // Directed vectors with one-cycle latency check
        for (int i = 0; i < 11; i++) begin
            if (i == 5) chk("sticky_before_sat", sat_sticky, 1'b0);
            round_mode = vecs[i].mode;
            in_data    = {vecs[i].l1, vecs[i].l0};
            in_vld     = 1'b1;
            @(negedge clk);
            in_vld = 1'b0;
            chk($sformatf("vec%0d_vld", i), out_vld, 1'b1);
            chk($sformatf("vec%0d_data", i), out_data, {vecs[i].e1, vecs[i].e0});
            chk($sformatf("vec%0d_sat", i), out_sat, vecs[i].es);
            @(negedge clk);
            chk($sformatf("vec%0d_vld_drop", i), out_vld, 1'b0);
        end
        chk("sticky_set", sat_sticky, 1'b1);

        // Clear pulse, then clear concurrent with a new saturation
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("sticky_cleared", sat_sticky, 1'b0);
        @(negedge clk);
        chk("sticky_stays_clear", sat_sticky, 1'b0);
        round_mode = 2'd1;
        in_data    = {22'h000000, 22'h1FFFFF};
        in_vld     = 1'b1;
        sat_clr    = 1'b1;
        @(negedge clk);
        in_vld  = 1'b0;
        sat_clr = 1'b0;
        chk("sticky_set_wins", sat_sticky, 1'b1);
        chk("set_wins_sat", out_sat, 2'b01);
        @(negedge clk);

        // Backpressure: A, B fill the buffer, C is held until space frees
        for (int i = 0; i < 3; i++) begin
            bd[i] = rnd_beat(i + 1);
            bm[i] = 2'($urandom_range(0, 3));
            mdl_beat(bd[i], bm[i], be_d[i], be_s[i]);
        end
        out_rdy = 1'b0;
        in_data = bd[0]; round_mode = bm[0]; in_vld = 1'b1;
        @(negedge clk);
        chk("bp_rdy_after_a", in_rdy, 1'b1);
        in_data = bd[1]; round_mode = bm[1];
        @(negedge clk);
        chk("bp_rdy_low_after_b", in_rdy, 1'b0);
        chk("bp_head_a", out_data, be_d[0]);
        in_data = bd[2]; round_mode = bm[2];
        @(negedge clk);
        chk("bp_rdy_still_low", in_rdy, 1'b0);
        chk("bp_stall_stable", out_data, be_d[0]);
        chk("bp_stall_sat", out_sat, be_s[0]);
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rdy_back", in_rdy, 1'b1);
        chk("bp_out_b", out_data, be_d[1]);
        chk("bp_sat_b", out_sat, be_s[1]);
        @(negedge clk);
        in_vld = 1'b0;
        chk("bp_vld_c", out_vld, 1'b1);
        chk("bp_out_c", out_data, be_d[2]);
        chk("bp_sat_c", out_sat, be_s[2]);
        @(negedge clk);
        chk("bp_drained", out_vld, 1'b0);

        // Continuous streaming against the reference model
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                chk($sformatf("st%0d_vld", i), out_vld, 1'b1);
                chk($sformatf("st%0d_rdy", i), in_rdy, 1'b1);
                if (q_d.size() > 0) begin
                    chk($sformatf("st%0d_data", i), out_data, q_d.pop_front());
                    chk($sformatf("st%0d_sat", i), out_sat, q_s.pop_front());
                end else begin
                    chk($sformatf("st%0d_model_empty", i), 1'b1, 1'b0);
                end
            end
            if (i < 20) begin
                in_data    = rnd_beat(i);
                round_mode = 2'($urandom_range(0, 3));
                in_vld     = 1'b1;
                if (in_rdy) begin
                    mdl_beat(in_data, round_mode, ed, es);
                    q_d.push_back(ed);
                    q_s.push_back(es);
                end
            end else begin
                in_vld = 1'b0;
            end
            @(negedge clk);
        end
        chk("st_drained", out_vld, 1'b0);

        // Asynchronous reset with two saturating beats buffered
        out_rdy    = 1'b0;
        round_mode = 2'd1;
        in_data    = {22'h000010, 22'h1FFFFF};
        in_vld     = 1'b1;
        repeat (2) @(negedge clk);
        in_vld = 1'b0;
        chk("rst_pre_full", in_rdy, 1'b0);
        #2 nreset = 1'b0;
        #1;
        chk("rst_async_vld", out_vld, 1'b0);
        chk("rst_async_data", out_data, '0);
        chk("rst_async_sat", out_sat, '0);
        chk("rst_async_rdy", in_rdy, 1'b1);
        chk("rst_async_sticky", sat_sticky, 1'b0);
        @(negedge clk);
        nreset  = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale%0d", i), out_vld, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/op_rescale_multi.md
Name: op_rescale_multi

Overview:
- Parametrised successor to the CORDIC output downscaler.
- Narrows NUM_CH CORDIC-width lanes to DATA_WIDTH per beat, with selectable rounding (truncate, round-half-up, convergent) and saturation on overflow.
- Uses a valid/ready handshake with a 2-entry output skid buffer, so in_rdy is a registered signal.
- Sits between the CORDIC core outputs and downstream FastICA datapath consumers.

Parameters:
- CORDIC_WIDTH, 22, input lane width (signed two's complement); must be greater than DATA_WIDTH.
- DATA_WIDTH, 16, output lane width (signed).
- NUM_CH, 2, number of lanes processed in lock-step (2 = x/y).

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  block can accept a beat; registered.
- in_data  in  NUM_CH*CORDIC_WIDTH  lanes packed; lane k occupies bits [k*CORDIC_WIDTH +: CORDIC_WIDTH].
- round_mode  in  2  0 = truncate, 1 = round-half-up, 2 = convergent, 3 = reserved (behaves as truncate); sampled with each accepted beat.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  downstream accepts the beat.
- out_data  out  NUM_CH*DATA_WIDTH  lanes packed, same ordering as in_data.
- out_sat  out  NUM_CH  per-lane flag: this output beat was saturated.
- sat_sticky  out  1  OR of all saturations since reset or the last clear.
- sat_clr  in  1  clears sat_sticky.

Behaviour:
- Let S = CORDIC_WIDTH-DATA_WIDTH.
- Truncate: result = in[CW-1:S], i.e. floor toward -inf. Never saturates.
- Round-half-up: compute (in + 2^(S-1)) at CW+1 bits, then take bits [CW:S].
- Convergent: same as round-half-up, except on an exact tie (low S bits == 1 followed by S-1 zeros) round toward the even result, i.e. add 2^(S-1) only if bit S is 1.
- Saturation: if the rounded value exceeds 2^(DW-1)-1, output 0x7FF..F and set out_sat for that lane. Negative overflow cannot occur.
- Accept: a beat is accepted when in_vld & in_rdy at a rising edge. Rounding is combinational from in_data and round_mode; the result is written into a 2-entry FIFO.
- Latency: a beat accepted at edge N appears with out_vld=1 after edge N (1 cycle).
- Pop: occurs when out_vld & out_rdy. Push and pop in the same cycle leave occupancy unchanged.
- in_rdy = (occupancy != 2), derived from the occupancy register.
  - With occupancy 2 and a pop, in_rdy rises the next cycle; no same-cycle pass-through.
- Ordering: strict FIFO. out_data and out_sat hold stable while out_vld=1 and out_rdy=0.
- Occupancy values 0, 1, 2 act as states EMPTY, ONE, FULL:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop.
- sat_sticky:
  - Set when any lane saturates on an accepted beat.
  - Cleared by sat_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset (async assert, at any time, including mid-transfer):
  - occupancy 0, out_vld 0, out_data 0, out_sat 0, sat_sticky 0, in_rdy 1.
  - Buffered beats are discarded.
- in_vld with in_rdy=0: no accept. The source must hold the beat.
- round_mode 3: identical to 0.

Decomposition:
- Shared package cordic_pkg:
  - Constants RND_TRUNC=2'd0, RND_HALFUP=2'd1, RND_CONV=2'd2.
  - Lane-packing helper macros/functions.
- Sub-module op_round_sat: a purely combinational single-lane round and saturate block.
  - Parameters CORDIC_WIDTH, DATA_WIDTH.
  - Ports in, mode, out, sat.
  - Instantiated NUM_CH times by generate.
- The top level holds the 2-entry FIFO, occupancy, handshake and sticky logic.

Test Plan:
- Defaults are CW=22, DW=16, S=6. The first four scenarios use out_rdy=1 unless noted.
- Truncate: lane0=0x000045 (69), lane1=0x3FFFBB (-69) -> out 0x0001, 0xFFFE; out_sat=00; out_vld exactly one cycle after accept.
- Half-up vs convergent:
  - Lane0=0x000060 (1.5): half-up -> 0x0002, convergent -> 0x0002.
  - Lane1=0x0000A0 (2.5): half-up -> 0x0003, convergent -> 0x0002.
  - 0x000050 (1.25) -> 0x0001 in both modes.
- Saturation:
  - Lane0=0x1FFFFF in half-up -> 0x7FFF, out_sat[0]=1, sat_sticky=1.
  - Same value in truncate -> 0x7FFF, out_sat=0.
  - sat_clr pulse -> sticky 0.
  - sat_clr concurrent with a new saturation -> sticky stays 1.
- Backpressure:
  - out_rdy=0; offer beats A, B, C -> A and B accepted; in_rdy=0 the cycle after B is accepted; C is held.
  - Raise out_rdy -> outputs A, B, C in order; out_data stable while stalled.
- Streaming: in_vld=1 and out_rdy=1 continuously for 20 beats with random data -> one output per cycle, in_rdy never drops, results match the reference model.
- Reset with 2 beats buffered: assert nreset mid-cycle -> out_vld=0, out_data=0, in_rdy=1 immediately; no stale beat after release.
